fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage directly upstream of `imm_generator` and the decoder. It holds the program counter and issues word fetches to instruction memory over a request/acknowledge handshake. It captures each returned word into an instruction register and classifies its opcode into the immediate-format code that `imm_generator` consumes on `type_i`. It presents instruction, PC and format to decode with a valid/ready handshake, and accepts branch/jump redirects from execute.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: reset; one clock; reset is asynchronous and active-high.
- `mem_req` out 1: fetch request, held until `mem_ack`.
- `mem_addr` out 32: fetch address, equals internal PC.
- `mem_ack` in 1: memory has `mem_rdata` valid this cycle; ignored when `mem_req`=0.
- `mem_rdata` in 32: fetched instruction word.
- `redirect_en` in 1: taken branch/jump from execute.
- `redirect_pc` in 32: redirect target.
- `inst_valid` out 1: `inst`/`pc_o`/`type_o` valid for decode.
- `inst_ready` in 1: decode accepts this cycle.
- `inst` out 32: captured instruction; drives `imm_generator.inst`.
- `type_o` out 3: format code (`inst_t`); drives `imm_generator.type_i`.
- `pc_o` out 32: address of `inst`.
- `fault` out 1: misaligned redirect seen; sticky until reset.

## Operation
- The FSM has four states: IDLE, FETCH, HOLD and FAULT.
- Reset drives the following:
  - state=IDLE, PC=`RESET_PC`.
  - `mem_req`=0, `inst_valid`=0, `fault`=0.
  - `inst`, `pc_o` and `type_o` are all 0.
- IDLE always moves to FETCH on the next cycle.
- FETCH:
  - Outputs: `mem_req`=1, `mem_addr`=PC, `inst_valid`=0.
  - On `mem_ack`: `inst`←`mem_rdata`, `type_o`←class(`mem_rdata`), `pc_o`←PC, PC←PC+4, then go to HOLD.
- HOLD: `mem_req`=0, `inst_valid`=1, and outputs stay stable. On `inst_ready`, go to FETCH.
- FAULT: `mem_req`=0, `inst_valid`=0, `fault`=1. Only `rst` exits this state.
- Redirect applies in any state except FAULT, and has priority over `mem_ack` and `inst_ready` in the same cycle.
  - If `redirect_pc[1:0]`==0: PC←`redirect_pc`, go to FETCH, `inst_valid` drops next cycle. An ack in the same cycle is discarded: `inst` and `pc_o` are not updated.
  - If `redirect_pc[1:0]`!=0: go to FAULT and leave PC unchanged.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.
- Classification uses opcode `inst[6:0]`, with codes I=1, S=2, SB=3, UJ=4, U=5:
  - 0010011, 0000011, 1100111, 1110011 → I.
  - 0100011 → S.
  - 1100011 → SB.
  - 1101111 → UJ.
  - 0110111, 0010111 → U.
  - All others, including R-type 0110011 → 0, for which `imm_generator` yields 0.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- After `rst` deasserts, the first rising edge enters FETCH, and `mem_req` is high from that cycle.
- If `mem_ack` arrives in the same cycle as `mem_req`, `inst_valid` goes high on the next cycle.
- Peak throughput is one instruction per 2 cycles: FETCH, then HOLD with `inst_ready`=1.
- `mem_addr` is constant while `mem_req` is high, except in the cycle after a redirect.
- Asserting `rst` mid-fetch aborts immediately. Memory must drop any pending response on `rst`.

## Structure
- Shared package `rv32_pkg` holds:
  - `inst_t` (I=1, S=2, SB=3, UJ=4, U=5) and an `INST_NONE`=0 constant.
  - Opcode constants.
  - The FSM state enum.
- `imm_generator` imports `inst_t` from `rv32_pkg`.
- Sub-module `opcode_classifier`: combinational, `inst[6:0]` → `inst_t`. It is shared with decode.

## Test plan
- Reset with `RESET_PC`=32'h100 and single-cycle ack:
  - `mem_addr` sequence is 0x100, 0x104, 0x108.
  - `pc_o` matches each captured word.
  - `inst_valid` pulses every 2 cycles with `inst_ready`=1.
- Feed the words below; `type_o` must be 1, 2, 3, 4, 5, 0 respectively:
  - 32'h00500093 (addi)
  - 32'h00112023 (sw)
  - 32'h00208463 (beq)
  - 32'h008000EF (jal)
  - 32'h000010B7 (lui)
  - 32'h002081B3 (add)
- Hold `inst_ready`=0 for 5 cycles in HOLD:
  - `inst`, `pc_o` and `type_o` stay stable.
  - `mem_req` stays 0.
  - Fetch resumes one cycle after ready.
- `redirect_en`=1, `redirect_pc`=0x200, in the same cycle as `mem_ack`:
  - The acked word is discarded.
  - The next `mem_addr` is 0x200.
  - The next valid `pc_o` is 0x200.
- `redirect_pc`=0x202:
  - `fault`=1 next cycle and `mem_req`=0.
  - The block stays in FAULT under any inputs until `rst`, after which `fault`=0 and `mem_addr`=`RESET_PC`.
- PC wrap: redirect to 0xFFFF_FFFC; the fetch after it uses `mem_addr`=0x0000_0000.

Source files
------------

// File: rtl/rv32_pkg.sv
// ----------------------------------------------------------------------------
// rv32_pkg
// Shared RV32 front-end definitions used by fetch_unit, opcode_classifier,
// imm_generator and decode.
//   inst_t         : immediate-format code consumed by imm_generator.type_i.
//   OP_*           : 7-bit major opcodes (inst[6:0]).
//   fetch_state_t  : fetch_unit FSM states.
//   is_word_aligned: true when the low two address bits are zero.
// ----------------------------------------------------------------------------
package rv32_pkg;

  // INST_NONE covers R-type and unknown opcodes; imm_generator yields 0 for it.
  typedef enum logic [2:0] {
    INST_NONE = 3'd0,
    INST_I    = 3'd1,
    INST_S    = 3'd2,
    INST_SB   = 3'd3,
    INST_UJ   = 3'd4,
    INST_U    = 3'd5
  } inst_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_t;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/opcode_classifier.sv
// ----------------------------------------------------------------------------
// opcode_classifier
// Combinational map from the major opcode to the immediate-format code.
// Shared between fetch_unit and decode.
//   opcode_i : inst[6:0]
//   type_o   : immediate format (INST_NONE for R-type and unknown opcodes)
// ----------------------------------------------------------------------------
module opcode_classifier
  import rv32_pkg::*;
(
  input  logic [6:0] opcode_i,
  output inst_t      type_o
);

  // NOTE: every path through an always_comb must assign every output, so a
  // default comes first; otherwise synthesis infers a latch to hold the value.
  always_comb begin
    type_o = INST_NONE;
    case (opcode_i)
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: type_o = INST_I;
      OP_STORE:                            type_o = INST_S;
      OP_BRANCH:                           type_o = INST_SB;
      OP_JAL:                              type_o = INST_UJ;
      OP_LUI, OP_AUIPC:                    type_o = INST_U;
      OP_OP:                               type_o = INST_NONE;
      default:                             type_o = INST_NONE;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: holds the PC, fetches words over a req/ack
// handshake, captures them with their PC and immediate format, and hands
// them to decode over valid/ready. Execute can redirect the PC; a misaligned
// redirect parks the unit in a sticky fault state until reset.
//   clk, rst              : clock, asynchronous active-high reset
//   mem_req/addr/ack/rdata: instruction memory handshake (addr == PC)
//   redirect_en/pc        : branch/jump target from execute
//   inst_valid/ready      : decode handshake for inst, pc_o, type_o
//   inst, pc_o, type_o    : captured word, its address, its format code
//   fault                 : misaligned redirect seen (sticky)
// All outputs come straight from registers; no input reaches an output
// combinationally.
// ----------------------------------------------------------------------------
module fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [2:0]  type_o,
  output logic [31:0] pc_o,
  output logic        fault
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  inst_pc_q, inst_pc_d;
  inst_t        type_q, type_d;
  inst_t        rdata_type;

  opcode_classifier u_classifier (
    .opcode_i (mem_rdata[6:0]),
    .type_o   (rdata_type)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    type_d    = type_q;

    unique case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ack) begin
          inst_d    = mem_rdata;
          type_d    = rdata_type;
          inst_pc_d = pc_q;
          pc_d      = pc_q + 32'd4;  // wraps modulo 2^32
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD:  if (inst_ready) state_d = ST_FETCH;
      ST_FAULT: state_d = ST_FAULT;
    endcase

    // A redirect overrides whatever the state logic above decided, including
    // a capture from an ack in the same cycle (that word is on the wrong path).
    if (redirect_en && state_q != ST_FAULT) begin
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      type_d    = type_q;
      if (is_word_aligned(redirect_pc)) begin
        pc_d    = redirect_pc;
        state_d = ST_FETCH;
      end else begin
        pc_d    = pc_q;
        state_d = ST_FAULT;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
      type_q    <= INST_NONE;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      type_q    <= type_d;
    end
  end

  assign mem_req    = (state_q == ST_FETCH);
  assign mem_addr   = pc_q;
  assign inst_valid = (state_q == ST_HOLD);
  assign fault      = (state_q == ST_FAULT);
  assign inst       = inst_q;
  assign pc_o       = inst_pc_q;
  assign type_o     = type_q;

endmodule
